// File: rtl/franken_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : franken_pkg
//  Description : Shared types and constants for the franken memory arbiter.
//                Holds the arbiter state encoding and the default fetch
//                constants (abort NOP and reset PC).
//  Revision    : 1.0 - initial release
// ============================================================================
package franken_pkg;

    // Arbiter state encoding: idle, data access in flight, fetch in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DACC = 2'd1,
        ST_IACC = 2'd2
    } arb_state_t;

    // addi x0,x0,0 - handed to the core when a fetch is aborted
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    // Tag value held by the fetch buffer out of reset
    localparam logic [31:0] c_reset_pc  = 32'h0040_0000;

    // Full-word byte enable used for fetches and loads
    localparam logic [3:0]  c_be_full   = 4'hF;

endpackage : franken_pkg
`default_nettype wire

// File: rtl/franken_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : franken_mem_arbiter
//  Description : Shares one single-ported memory between the core's
//                instruction fetch and its MEM-stage data access. Data
//                accesses win over fetches. The fetched instruction and the
//                loaded word are held in registers so the core sees stable
//                values while stalled on rbusy. A request that waits too long
//                for mem_ready is aborted with substituted data and a sticky
//                bus_err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module franken_mem_arbiter
    import franken_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NOP_INSTR      = c_nop_instr,
    parameter logic [31:0] RESET_PC       = c_reset_pc
) (
    input  logic        clk,
    input  logic        reset,
    // core side
    input  logic [31:0] pc,
    input  logic        d_read_en,
    input  logic        d_write_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] instruction,
    output logic [31:0] read_data,
    output logic        rbusy,
    // memory side
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    localparam int                   c_wait_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_wait_w-1:0]  c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and its next-state counterparts
    // ------------------------------------------------------------------
    arb_state_t             r_state,       w_state_nxt;
    logic                   r_mem_req,     w_mem_req_nxt;
    logic                   r_mem_we,      w_mem_we_nxt;
    logic [31:0]            r_mem_addr,    w_mem_addr_nxt;
    logic [31:0]            r_mem_wdata,   w_mem_wdata_nxt;
    logic [3:0]             r_mem_be,      w_mem_be_nxt;
    logic [31:0]            r_instruction, w_instruction_nxt;
    logic [31:0]            r_read_data,   w_read_data_nxt;
    logic                   r_bus_err,     w_bus_err_nxt;
    logic                   r_i_valid,     w_i_valid_nxt;
    logic [31:0]            r_i_tag,       w_i_tag_nxt;
    logic [31:0]            r_req_pc,      w_req_pc_nxt;
    logic                   r_d_done,      w_d_done_nxt;
    logic [c_wait_w-1:0]    r_wait_cnt,    w_wait_cnt_nxt;

    logic                   w_d_pend;
    logic                   w_i_pend;
    logic                   w_rbusy;
    logic                   w_timeout;
    logic                   w_finish;
    logic [1:0]             w_unused_addr_lsbs;

    // Memory is word addressed; the byte offset of a data access travels
    // only through the byte enables the core already lane-shifted.
    assign w_unused_addr_lsbs = d_addr[1:0];

    // A data access is outstanding until it has been served once.
    assign w_d_pend  = (d_read_en | d_write_en) & ~r_d_done;

    // The fetch buffer only counts when it holds the word for the current pc.
    assign w_i_pend  = ~(r_i_valid & (r_i_tag == pc));

    assign w_rbusy   = w_d_pend | w_i_pend | (r_state != ST_IDLE);

    // Abort fires on the last permitted wait cycle if memory stays silent.
    assign w_timeout = ~mem_ready & (r_wait_cnt == c_wait_last);
    assign w_finish  = mem_ready | w_timeout;

    // Next-state and next-output computation for the arbiter FSM
    always_comb begin
        w_state_nxt       = r_state;
        w_mem_req_nxt     = r_mem_req;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_mem_be_nxt      = r_mem_be;
        w_instruction_nxt = r_instruction;
        w_read_data_nxt   = r_read_data;
        w_bus_err_nxt     = r_bus_err;
        w_i_valid_nxt     = r_i_valid;
        w_i_tag_nxt       = r_i_tag;
        w_req_pc_nxt      = r_req_pc;
        w_d_done_nxt      = r_d_done;
        w_wait_cnt_nxt    = r_wait_cnt;

        // The core has seen rbusy low, so a held enable is a new request.
        if (!w_rbusy) begin
            w_d_done_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_d_pend) begin
                    w_state_nxt     = ST_DACC;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_write_en;
                    w_mem_addr_nxt  = {d_addr[31:2], 2'b00};
                    w_mem_wdata_nxt = d_wdata;
                    w_mem_be_nxt    = d_write_en ? d_be : c_be_full;
                    w_wait_cnt_nxt  = '0;
                end else if (w_i_pend) begin
                    w_state_nxt     = ST_IACC;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = {pc[31:2], 2'b00};
                    w_mem_be_nxt    = c_be_full;
                    w_req_pc_nxt    = pc;
                    w_wait_cnt_nxt  = '0;
                end
            end

            ST_DACC: begin
                if (w_finish) begin
                    w_state_nxt   = ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_d_done_nxt  = 1'b1;
                    // Stores leave the load register untouched.
                    if (!r_mem_we) begin
                        w_read_data_nxt = mem_ready ? mem_rdata : 32'h0;
                    end
                    if (w_timeout) begin
                        w_bus_err_nxt = 1'b1;
                    end
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            ST_IACC: begin
                if (w_finish) begin
                    w_state_nxt       = ST_IDLE;
                    w_mem_req_nxt     = 1'b0;
                    w_instruction_nxt = mem_ready ? mem_rdata : NOP_INSTR;
                    // Tag with the address actually fetched; a pc change in
                    // flight shows up as a tag miss afterwards.
                    w_i_tag_nxt       = r_req_pc;
                    w_i_valid_nxt     = 1'b1;
                    if (w_timeout) begin
                        w_bus_err_nxt = 1'b1;
                    end
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State register; reset drops any transfer in flight immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_mem_be      <= 4'h0;
            r_instruction <= NOP_INSTR;
            r_read_data   <= 32'h0;
            r_bus_err     <= 1'b0;
            r_i_valid     <= 1'b0;
            r_i_tag       <= RESET_PC;
            r_req_pc      <= RESET_PC;
            r_d_done      <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_mem_be      <= w_mem_be_nxt;
            r_instruction <= w_instruction_nxt;
            r_read_data   <= w_read_data_nxt;
            r_bus_err     <= w_bus_err_nxt;
            r_i_valid     <= w_i_valid_nxt;
            r_i_tag       <= w_i_tag_nxt;
            r_req_pc      <= w_req_pc_nxt;
            r_d_done      <= w_d_done_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    assign instruction = r_instruction;
    assign read_data   = r_read_data;
    assign rbusy       = w_rbusy;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_be      = r_mem_be;
    assign bus_err     = r_bus_err;

endmodule : franken_mem_arbiter
`default_nettype wire

// File: tb/tb_franken_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_franken_mem_arbiter
//  Description : Scoreboard bench for franken_mem_arbiter. The core driver
//                pushes the expected memory transactions and the expected
//                core-visible result of every operation; a memory responder
//                and a result monitor pop and compare independently.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_franken_mem_arbiter;
    import franken_pkg::*;

    localparam int          c_to  = 8;
    localparam logic [31:0] c_rpc = 32'h0040_0000;
    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        d_read_en, d_write_en;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] instruction, read_data;
    logic        rbusy;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    franken_mem_arbiter #(
        .TIMEOUT_CYCLES (c_to),
        .NOP_INSTR      (c_nop),
        .RESET_PC       (c_rpc)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .d_read_en   (d_read_en),
        .d_write_en  (d_write_en),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_be        (d_be),
        .instruction (instruction),
        .read_data   (read_data),
        .rbusy       (rbusy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] rdata;
        logic        berr;
    } res_t;

    txn_t exp_txn[$];
    res_t exp_res[$];
    int   total = 0;
    int   bad   = 0;

    // Reference memory (model view) and physical memory (responder view)
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    // Core-visible model state
    logic        m_valid;
    logic [31:0] m_tag, m_inst, m_read;
    logic        m_berr;

    // Responder / monitor control
    bit   mute        = 1'b0;
    int   force_delay = -1;
    bit   busy_seen   = 1'b0;
    int   cnt         = 0;
    txn_t cur;
    int   req_hi_cnt  = 0;
    bit   op_active   = 1'b0;
    int   rbusy_hi_cnt = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Memory responder: checks each new request against the scoreboard,
    // checks it stays stable, and answers after a random delay.
    initial begin
        txn_t now;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (reset || !mem_req) begin
                busy_seen = 1'b0;
            end else begin
                now = '{mem_we, mem_addr, mem_we ? mem_wdata : 32'h0, mem_be};
                if (!busy_seen) begin
                    if (exp_txn.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got %0h expected none at %0t", now, $time);
                    end else begin
                        check("req", 96'(now), 96'(exp_txn.pop_front()));
                    end
                    cur       = now;
                    busy_seen = 1'b1;
                    cnt       = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                end else begin
                    check("req_stable", 96'(now), 96'(cur));
                end
                if (mute) begin
                    req_hi_cnt++;
                end else if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = phys_rd(mem_addr);
                    if (mem_we) phys_mem[mem_addr] = merge(phys_rd(mem_addr), mem_wdata, mem_be);
                    busy_seen = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Result monitor: when the core is released, compare its view
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (op_active && !reset) begin
                if (rbusy) begin
                    rbusy_hi_cnt++;
                end else begin
                    if (exp_res.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL result: got release expected none at %0t", $time);
                    end else begin
                        r = exp_res.pop_front();
                        check("instruction", 96'(instruction), 96'(r.inst));
                        check("read_data",   96'(read_data),   96'(r.rdata));
                        check("bus_err",     96'(bus_err),     96'(r.berr));
                    end
                    check("txn_left", 96'(exp_txn.size()), 96'(0));
                    op_active = 1'b0;
                end
            end
        end
    end

    // Issue one core operation: kind 0 none, 1 load, 2 store
    task automatic issue_op(input logic [31:0] npc, input int kind, input logic [31:0] daddr,
                            input logic [31:0] wdata, input logic [3:0] be, input bit abort);
        logic [31:0] w;
        w = {daddr[31:2], 2'b00};
        if (kind == 1) begin
            exp_txn.push_back('{1'b0, w, 32'h0, 4'hF});
            m_read = abort ? 32'h0 : ref_rd(w);
            if (abort) m_berr = 1'b1;
        end else if (kind == 2) begin
            exp_txn.push_back('{1'b1, w, wdata, be});
            ref_mem[w] = merge(ref_rd(w), wdata, be);
        end
        if (!(m_valid && m_tag == npc)) begin
            exp_txn.push_back('{1'b0, {npc[31:2], 2'b00}, 32'h0, 4'hF});
            m_valid = 1'b1;
            m_tag   = npc;
            m_inst  = abort ? c_nop : ref_rd({npc[31:2], 2'b00});
            if (abort) m_berr = 1'b1;
        end
        exp_res.push_back('{m_inst, m_read, m_berr});
        pc           = npc;
        d_read_en    = (kind == 1);
        d_write_en   = (kind == 2);
        d_addr       = daddr;
        d_wdata      = wdata;
        d_be         = be;
        rbusy_hi_cnt = 0;
        op_active    = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int b;
        b = 0;
        while (op_active && b < 300) begin
            @(posedge clk);
            b++;
        end
        if (op_active) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got rbusy=1 expected release within 300 cycles", name);
            summary();
        end
        #1;
        d_read_en  = 1'b0;
        d_write_en = 1'b0;
    endtask

    task automatic wait_mem_req(input bit level);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (mem_req !== level && b < 100);
        if (mem_req !== level) begin
            total++;
            bad++;
            $display("FAIL mem_req_wait: got %0b expected %0b", mem_req, level);
            summary();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Main stimulus
    initial begin
        logic [31:0] npc, da, wd, pa;
        logic [3:0]  be;
        int          kind;

        reset      = 1'b1;
        pc         = c_rpc;
        d_read_en  = 1'b0;
        d_write_en = 1'b0;
        d_addr     = 32'h0;
        d_wdata    = 32'h0;
        d_be       = 4'h0;
        m_valid    = 1'b0;
        m_tag      = c_rpc;
        m_inst     = c_nop;
        m_read     = 32'h0;
        m_berr     = 1'b0;
        ref_mem[c_rpc]  = 32'h0050_0093;
        phys_mem[c_rpc] = 32'h0050_0093;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",     96'(mem_req),     96'(0));
        check("rst_mem_be",      96'(mem_be),      96'(0));
        check("rst_instruction", 96'(instruction), 96'(c_nop));
        check("rst_read_data",   96'(read_data),   96'(0));
        check("rst_bus_err",     96'(bus_err),     96'(0));

        // First fetch after reset with single-cycle memory
        reset       = 1'b0;
        force_delay = 0;
        issue_op(c_rpc, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        wait_done("t1");
        check("t1_rbusy_cycles", 96'(rbusy_hi_cnt), 96'(2));
        force_delay = -1;

        // Load and fetch miss together: load goes first
        issue_op(c_rpc + 32'h4, 1, 32'h1001_0004, 32'h0, 4'hF, 1'b0);
        wait_done("t2");

        // Store held across a slow fetch: exactly one write transfer
        force_delay = 3;
        issue_op(c_rpc + 32'h8, 2, 32'h1001_0003, 32'hAB00_0000, 4'b1000, 1'b0);
        wait_done("t3");
        force_delay = -1;
        issue_op(c_rpc + 32'h8, 1, 32'h1001_0000, 32'h0, 4'hF, 1'b0);
        wait_done("t3_readback");

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            npc  = c_rpc + 32'($urandom_range(0, 5)) * 32'd4;
            kind = int'($urandom_range(0, 2));
            da   = 32'h1001_0000 + 32'($urandom_range(0, 15));
            wd   = $urandom;
            be   = 4'($urandom_range(1, 15));
            issue_op(npc, kind, da, wd, be, 1'b0);
            wait_done("rand");
        end

        // pc change while a fetch is in flight
        pa = 32'h0040_0040;
        exp_txn.push_back('{1'b0, pa, 32'h0, 4'hF});
        exp_txn.push_back('{1'b0, pa + 32'h4, 32'h0, 4'hF});
        m_valid = 1'b1;
        m_tag   = pa + 32'h4;
        m_inst  = ref_rd(pa + 32'h4);
        exp_res.push_back('{m_inst, m_read, m_berr});
        force_delay  = 2;
        pc           = pa;
        rbusy_hi_cnt = 0;
        op_active    = 1'b1;
        wait_mem_req(1'b1);
        @(posedge clk);
        #1;
        pc = pa + 32'h4;
        wait_mem_req(1'b0);
        check("t6_first_word", 96'(instruction), 96'(ref_rd(pa)));
        check("t6_still_busy", 96'(rbusy),       96'(1));
        wait_done("t6");
        force_delay = -1;

        // Fetch timeout: memory never answers
        mute       = 1'b1;
        req_hi_cnt = 0;
        issue_op(32'h0040_0100, 0, 32'h0, 32'h0, 4'h0, 1'b1);
        wait_done("t4");
        check("t4_wait_cycles", 96'(req_hi_cnt), 96'(c_to));
        mute = 1'b0;

        // bus_err must stay set through further traffic
        for (int i = 0; i < 6; i++) begin
            npc  = c_rpc + 32'($urandom_range(0, 5)) * 32'd4;
            kind = int'($urandom_range(0, 2));
            da   = 32'h1001_0000 + 32'($urandom_range(0, 15));
            issue_op(npc, kind, da, $urandom, 4'($urandom_range(1, 15)), 1'b0);
            wait_done("rand_err");
        end

        // Reset in the middle of a data access
        mute = 1'b1;
        issue_op(m_tag, 1, 32'h1001_0008, 32'h0, 4'hF, 1'b0);
        wait_mem_req(1'b1);
        @(posedge clk);
        #3;
        reset     = 1'b1;
        op_active = 1'b0;
        #1;
        check("t5_mem_req",     96'(mem_req),     96'(0));
        check("t5_mem_we",      96'(mem_we),      96'(0));
        check("t5_mem_addr",    96'(mem_addr),    96'(0));
        check("t5_mem_be",      96'(mem_be),      96'(0));
        check("t5_instruction", 96'(instruction), 96'(c_nop));
        check("t5_read_data",   96'(read_data),   96'(0));
        check("t5_bus_err",     96'(bus_err),     96'(0));
        exp_txn.delete();
        exp_res.delete();
        m_valid    = 1'b0;
        m_inst     = c_nop;
        m_read     = 32'h0;
        m_berr     = 1'b0;
        d_read_en  = 1'b0;
        d_write_en = 1'b0;
        pc         = c_rpc;
        mute       = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue_op(c_rpc, 0, 32'h0, 32'h0, 4'h0, 1'b0);
        wait_done("t5_refetch");

        repeat (3) @(posedge clk);
        summary();
    end

endmodule : tb_franken_mem_arbiter
`default_nettype wire
